// File: rtl/alu_sub_sequencer.sv
// Byte-serial sequencer for the 16-bit subtract/flags ALU: 4-byte request in, 3-byte response out.
// Optional inter-byte timeout enabled by defining ALU_SUB_SEQ_TIMEOUT_EN.
module alu_sub_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX1,
    S_RX2,
    S_RX3,
    S_EXEC,
    S_TX0,
    S_TX1,
    S_TX2
  } state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] r_q, r_d;
  logic [4:0]  f_q, f_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic [16:0] diff;
  logic        flag_v;
  logic        flag_c;
  logic        flag_n;
  logic        flag_z;
  logic        flag_p;
  logic        tx_fire;
  logic        timeout_hit;

`ifdef ALU_SUB_SEQ_TIMEOUT_EN
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] gap_q, gap_d;

  // Counter is held at zero outside RX1-RX3, which also clears it on entry to RX1.
  always_comb begin
    gap_d       = '0;
    timeout_hit = 1'b0;
    if (state_q inside {S_RX1, S_RX2, S_RX3}) begin
      if (rx_valid) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        timeout_hit = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // 17-bit subtract: bit 16 is the unsigned borrow.
  always_comb begin
    diff   = {1'b0, a_q} - {1'b0, b_q};
    flag_v = (a_q[15] ^ b_q[15]) & (diff[15] ^ a_q[15]);
    flag_c = diff[16];
    flag_n = diff[15];
    flag_z = (diff[15:0] == 16'h0000);
    flag_p = ~^diff[15:0];
  end

  assign tx_fire = tx_valid_q & tx_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    f_d        = f_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          a_d[15:8] = rx_data;
          state_d   = S_RX1;
        end
      end
      S_RX1: begin
        if (rx_valid) begin
          a_d[7:0] = rx_data;
          state_d  = S_RX2;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RX2: begin
        if (rx_valid) begin
          b_d[15:8] = rx_data;
          state_d   = S_RX3;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RX3: begin
        if (rx_valid) begin
          b_d[7:0] = rx_data;
          state_d  = S_EXEC;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        overrun_d  = rx_valid;
        r_d        = diff[15:0];
        f_d        = {flag_v, flag_c, flag_n, flag_z, flag_p};
        tx_data_d  = diff[15:8];
        tx_valid_d = 1'b1;
        state_d    = S_TX0;
      end
      S_TX0: begin
        overrun_d = rx_valid;
        if (tx_fire) begin
          tx_data_d = r_q[7:0];
          state_d   = S_TX1;
        end
      end
      S_TX1: begin
        overrun_d = rx_valid;
        if (tx_fire) begin
          tx_data_d = {3'b000, f_q};
          state_d   = S_TX2;
        end
      end
      S_TX2: begin
        overrun_d = rx_valid;
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      f_q        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      f_q        <= f_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = state_q inside {S_EXEC, S_TX0, S_TX1, S_TX2};
  assign overrun  = overrun_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_alu_sub_sequencer.sv
// Randomized self-checking bench for alu_sub_sequencer against an arithmetic reference model.
module tb_alu_sub_sequencer;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_sub_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response bytes {R_hi, R_lo, F} from signed/unsigned integer arithmetic.
  function automatic logic [23:0] model_sub(input logic [15:0] a, input logic [15:0] b);
    int sa, sb, d;
    logic [15:0] r;
    logic v, c, n, z, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    r  = a - b;
    v  = (d > 32767) || (d < -32768);
    c  = int'(a) < int'(b);
    n  = r[15];
    z  = (r == 16'h0000);
    p  = ($countones(r) % 2) == 0;
    return {r, 3'b000, v, c, n, z, p};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int unsigned max_gap);
    send_byte(a[15:8], $urandom_range(0, max_gap));
    send_byte(a[7:0],  $urandom_range(0, max_gap));
    send_byte(b[15:8], $urandom_range(0, max_gap));
    send_byte(b[7:0],  $urandom_range(0, max_gap));
    check_eq("exec_busy", busy, 1);
    check_eq("exec_tx_valid", tx_valid, 0);
    @(negedge clk);
  endtask

  // mode 0: ready always; 1: random ready; 2: 10-cycle stall per byte.
  // inj 0: none; 1: random rx strobes; 2: one 0xAA strobe in TX1.
  task automatic collect(input logic [23:0] exp, input int unsigned mode, input int unsigned inj);
    logic [7:0]  expb [3];
    int unsigned got = 0;
    int unsigned cyc = 0;
    int unsigned stall = 0;
    logic        ready;
    logic        exp_ovr = 1'b0;
    logic        injected = 1'b0;
    expb[0] = exp[23:16];
    expb[1] = exp[15:8];
    expb[2] = exp[7:0];
    while (got < 3 && cyc < 400) begin
      check_eq("tx_valid", tx_valid, 1);
      check_eq("tx_data", tx_data, expb[got]);
      check_eq("busy", busy, 1);
      check_eq("overrun", overrun, exp_ovr);
      case (mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          ready = (stall >= 10);
          stall = ready ? 0 : stall + 1;
        end
      endcase
      exp_ovr = 1'b0;
      rx_valid = 1'b0;
      if ((inj == 1 && $urandom_range(0, 3) == 0) || (inj == 2 && got == 1 && !injected)) begin
        rx_valid = 1'b1;
        rx_data  = (inj == 2) ? 8'hAA : 8'($urandom);
        exp_ovr  = 1'b1;
        injected = 1'b1;
      end
      tx_ready = ready;
      if (ready) got++;
      @(negedge clk);
      cyc++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    check_eq("tx_count", got, 3);
    check_eq("end_overrun", overrun, exp_ovr);
    check_eq("end_busy", busy, 0);
    check_eq("end_tx_valid", tx_valid, 0);
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                           input int unsigned mode, input int unsigned inj);
    send_frame(a, b, 0);
    collect(model_sub(a, b), mode, inj);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_valid"}, tx_valid, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
  endtask

  logic [15:0] ra, rb;
  logic [15:0] corner [6];

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(16'h4E20, 16'hB1E0, 0, 0);
    run_frame(16'h0005, 16'h0005, 0, 0);
    run_frame(16'h7FFF, 16'h0001, 2, 0);
    run_frame(16'h7FFF, 16'hFFFF, 2, 0);
    run_frame(16'h1234, 16'h5678, 2, 2);
    run_frame(16'h0003, 16'h0007, 0, 0);
    check_eq("model_fffc", model_sub(16'h0003, 16'h0007), 24'hFFFC0D);

    // Partial frame then a long idle gap.
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check_eq("to_quiet", timeout, 0);
    end
    @(negedge clk);
`ifdef ALU_SUB_SEQ_TIMEOUT_EN
    check_eq("to_pulse", timeout, 1);
    @(negedge clk);
    check_eq("to_pulse_end", timeout, 0);
    run_frame(16'h0003, 16'h0007, 0, 0);
`else
    check_eq("to_none", timeout, 0);
    @(negedge clk);
    check_eq("to_none2", timeout, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    check_eq("pend_busy", busy, 1);
    @(negedge clk);
    collect(model_sub(16'h1234, 16'h0007), 0, 0);
`endif

    // Byte arriving exactly in the expiry cycle is accepted.
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 15);
    check_eq("to_edge", timeout, 0);
    send_byte(8'h07, 0);
    check_eq("to_edge_busy", busy, 1);
    @(negedge clk);
    collect(24'hFFFC0D, 0, 0);

    // Reset while stalled in TX1.
    send_frame(16'h4E20, 16'hB1E0, 0);
    check_eq("rst_pre_data", tx_data, 8'h9C);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pre_tx1", tx_data, 8'h40);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_frame(16'h0005, 16'h0005, 0, 0);

    corner[0] = 16'h0000;
    corner[1] = 16'h8000;
    corner[2] = 16'h7FFF;
    corner[3] = 16'hFFFF;
    corner[4] = 16'h0001;
    corner[5] = 16'h8001;
    for (int unsigned k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      send_frame(ra, rb, 3);
      collect(model_sub(ra, rb), $urandom_range(0, 1), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
